// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding, wait-counter
// width, default memory-window base and the byte-to-word shift helper.
`timescale 1ns/1ps
package sram_ctrl_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Byte address of SRAM word 0 in the pipeline data-memory window
    localparam int unsigned DEFAULT_BASE_ADDR = 1024;

    // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15
    localparam int WAIT_CNT_W = 4;

    // Number of low byte-address bits dropped when forming a word address
    function automatic int byte_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Clocked access engine between the MEM stage and an asynchronous SRAM.
// Each request is latched in IDLE, held on the bus for WAIT_CYCLES cycles in
// ACCESS, and acknowledged through a one-cycle DONE state; the pipeline is
// stalled via ready for the whole sequence.
`timescale 1ns/1ps
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          SRAM_ADDR_W = 17,
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    output logic                   addr_err,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    inout  wire  [DATA_W-1:0]      sram_dq
);

    localparam int                    SHIFT    = byte_shift(DATA_W);
    localparam logic [ADDR_W-1:0]     BASE_VEC = ADDR_W'(BASE_ADDR);
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [SRAM_ADDR_W-1:0] word_q, word_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   is_write_q, is_write_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   addr_err_q, addr_err_d;

    logic [ADDR_W-1:0]      offset;
    logic [ADDR_W-1:0]      word_full;
    logic                   below_base;
    logic                   above_top;
    logic                   req;
    logic                   drive_bus;

    assign req = rd_en || wr_en;

    // Map the byte address into SRAM word space and flag accesses outside the window
    always_comb begin
        offset     = address - BASE_VEC;
        word_full  = offset >> SHIFT;
        below_base = address < BASE_VEC;
        above_top  = (word_full >> SRAM_ADDR_W) != '0;
    end

    // Next-state, wait-counter and read-capture logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
        addr_err_d = addr_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // Write wins when both requests are raised together
                    state_d    = ST_ACCESS;
                    cnt_d      = CNT_LOAD;
                    word_d     = word_full[SRAM_ADDR_W-1:0];
                    wdata_d    = wdata;
                    is_write_d = wr_en;
                    if (below_base || above_top) begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (!is_write_q) begin
                        rdata_d = sram_dq;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Write-data holding register; only observed while a write is in ACCESS
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    // The bus is driven only during write ACCESS cycles; DONE always releases it
    assign drive_bus = (state_q == ST_ACCESS) && is_write_q;
    assign sram_we_n = !drive_bus;
    assign sram_dq   = drive_bus ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr = word_q;
    assign rdata     = rdata_q;
    assign addr_err  = addr_err_q;
    assign ready     = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: four controllers (WAIT_CYCLES 2, 1, 4, 15), each
// paired with a behavioural asynchronous SRAM whose read data only becomes
// valid READ_DELAY ns after the address or write enable last changed.
`timescale 1ns/1ps
module sram_model #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 17,
    parameter int READ_DELAY  = 18
) (
    input  logic [SRAM_ADDR_W-1:0] addr,
    input  logic                   we_n,
    input  logic                   oe,
    inout  wire  [DATA_W-1:0]      dq
);
    localparam int DEPTH = 1 << SRAM_ADDR_W;
    localparam logic [DATA_W-1:0] UNSETTLED = DATA_W'(32'hBAD0_BAD0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    realtime           last_change;

    always @(addr or we_n) last_change = $realtime;

    // Evaluated mid-way between bench time steps, away from clock edges
    initial begin
        rd_q = UNSETTLED;
        #0.5;
        forever begin
            if (!we_n) mem[addr] = dq;
            if (we_n && (($realtime - last_change) >= READ_DELAY)) rd_q = mem[addr];
            else rd_q = UNSETTLED;
            #1;
        end
    end

    assign dq = (oe && we_n) ? rd_q : {DATA_W{1'bz}};
endmodule

module tb_sram_controller;
    localparam int NI = 4;

    function automatic int wc(input int k);
        case (k)
            0: return 2;
            1: return 1;
            2: return 4;
            default: return 15;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en_a     [NI];
    logic        wr_en_a     [NI];
    logic        oe_a        [NI];
    logic [31:0] address_a   [NI];
    logic [31:0] wdata_a     [NI];
    logic [31:0] rdata_a     [NI];
    logic        ready_a     [NI];
    logic        addr_err_a  [NI];
    logic        we_n_a      [NI];
    logic [16:0] sram_addr_a [NI];
    logic [31:0] dq_a        [NI];

    int tests_run;
    int tests_failed;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int W = wc(g);
        tri0 [31:0] dq;

        sram_controller #(
            .DATA_W(32), .ADDR_W(32), .SRAM_ADDR_W(17), .BASE_ADDR(1024), .WAIT_CYCLES(W)
        ) u_dut (
            .clk(clk), .rst(rst), .rd_en(rd_en_a[g]), .wr_en(wr_en_a[g]),
            .address(address_a[g]), .wdata(wdata_a[g]), .rdata(rdata_a[g]),
            .ready(ready_a[g]), .addr_err(addr_err_a[g]), .sram_addr(sram_addr_a[g]),
            .sram_we_n(we_n_a[g]), .sram_dq(dq)
        );

        sram_model #(.DATA_W(32), .SRAM_ADDR_W(17), .READ_DELAY(W * 10 - 2)) u_sram (
            .addr(sram_addr_a[g]), .we_n(we_n_a[g]), .oe(oe_a[g]), .dq(dq)
        );

        assign dq_a[g] = dq;
    end

    // One complete handshaked access on instance k; records stall cycles,
    // write-enable-low cycles, the address shown during ACCESS, whether the
    // bus carried the write data, and rdata in the DONE cycle.
    task automatic do_access(input int k, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] data,
                             output int stall, output int we_low, output logic [16:0] acc_addr,
                             output logic dq_ok, output logic [31:0] rd_at_done);
        stall = 0; we_low = 0; acc_addr = '0; dq_ok = 1'b1; rd_at_done = '0;
        @(posedge clk); #1;
        rd_en_a[k] = rd; wr_en_a[k] = wr; address_a[k] = addr; wdata_a[k] = data;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!we_n_a[k]) begin
                we_low++;
                if (dq_a[k] !== data) dq_ok = 1'b0;
            end
            if (ready_a[k]) begin
                rd_at_done = rdata_a[k];
                break;
            end
            stall++;
            acc_addr = sram_addr_a[k];
        end
        @(posedge clk); #1;
        rd_en_a[k] = 1'b0; wr_en_a[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; oe_a[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (ready_a[0] !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b expected 1", ready_a[0]); end
        tests_run++; if (we_n_a[0] !== 1'b1) begin tests_failed++; $display("FAIL rst_we_n: got %b expected 1", we_n_a[0]); end
        tests_run++; if (sram_addr_a[0] !== 17'h0) begin tests_failed++; $display("FAIL rst_sram_addr: got %h expected 0", sram_addr_a[0]); end
        tests_run++; if (rdata_a[0] !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata: got %h expected 0", rdata_a[0]); end
        tests_run++; if (addr_err_a[0] !== 1'b0) begin tests_failed++; $display("FAIL rst_addr_err: got %b expected 0", addr_err_a[0]); end
        tests_run++; if (dq_a[0] !== 32'h0) begin tests_failed++; $display("FAIL rst_dq_released: got %h expected 0 (pulled-down bus)", dq_a[0]); end
        @(posedge clk); #1;
        rst = 1'b1; oe_a[0] = 1'b1;
    endtask

    task automatic test_write_read();
        int st, wl; logic [16:0] aa; logic ok; logic [31:0] rd;
        do_access(0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, st, wl, aa, ok, rd);
        tests_run++; if (st !== 3) begin tests_failed++; $display("FAIL wr_stall: got %0d expected 3", st); end
        tests_run++; if (wl !== 2) begin tests_failed++; $display("FAIL wr_we_low: got %0d expected 2", wl); end
        tests_run++; if (aa !== 17'd1) begin tests_failed++; $display("FAIL wr_sram_addr: got %h expected 1", aa); end
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL wr_dq: got bus mismatch flag %b expected 1", ok); end
        do_access(0, 1'b1, 1'b0, 32'd1028, 32'h0, st, wl, aa, ok, rd);
        tests_run++; if (st !== 3) begin tests_failed++; $display("FAIL rd_stall: got %0d expected 3", st); end
        tests_run++; if (wl !== 0) begin tests_failed++; $display("FAIL rd_we_low: got %0d expected 0", wl); end
        tests_run++; if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_collision();
        int st, wl; logic [16:0] aa; logic ok; logic [31:0] rd;
        do_access(0, 1'b1, 1'b1, 32'd1024, 32'h1234_5678, st, wl, aa, ok, rd);
        tests_run++; if (wl !== 2) begin tests_failed++; $display("FAIL coll_we_low: got %0d expected 2", wl); end
        tests_run++; if (aa !== 17'd0) begin tests_failed++; $display("FAIL coll_sram_addr: got %h expected 0", aa); end
        tests_run++; if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL coll_rdata_kept: got %h expected deadbeef", rd); end
        do_access(0, 1'b1, 1'b0, 32'd1024, 32'h0, st, wl, aa, ok, rd);
        tests_run++; if (rd !== 32'h1234_5678) begin tests_failed++; $display("FAIL coll_readback: got %h expected 12345678", rd); end
        do_access(0, 1'b1, 1'b0, 32'd1028, 32'h0, st, wl, aa, ok, rd);
        tests_run++; if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL coll_neighbour: got %h expected deadbeef", rd); end
    endtask

    task automatic test_range_err();
        int st, wl; logic [16:0] aa; logic ok; logic [31:0] rd;
        tests_run++; if (addr_err_a[0] !== 1'b0) begin tests_failed++; $display("FAIL err_initial: got %b expected 0", addr_err_a[0]); end
        do_access(0, 1'b1, 1'b0, 32'd1020, 32'h0, st, wl, aa, ok, rd);
        tests_run++; if (st !== 3) begin tests_failed++; $display("FAIL err_low_completes: got stall %0d expected 3", st); end
        tests_run++; if (aa !== 17'h1FFFF) begin tests_failed++; $display("FAIL err_low_addr: got %h expected 1ffff", aa); end
        tests_run++; if (addr_err_a[0] !== 1'b1) begin tests_failed++; $display("FAIL err_low_flag: got %b expected 1", addr_err_a[0]); end
        do_access(0, 1'b0, 1'b1, 32'd1032, 32'h5555_AAAA, st, wl, aa, ok, rd);
        tests_run++; if (addr_err_a[0] !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", addr_err_a[0]); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        tests_run++; if (addr_err_a[0] !== 1'b0) begin tests_failed++; $display("FAIL err_cleared: got %b expected 0", addr_err_a[0]); end
        do_access(0, 1'b0, 1'b1, 32'd525312, 32'hCAFE_F00D, st, wl, aa, ok, rd);
        tests_run++; if (addr_err_a[0] !== 1'b1) begin tests_failed++; $display("FAIL err_high_flag: got %b expected 1", addr_err_a[0]); end
        tests_run++; if (aa !== 17'd0) begin tests_failed++; $display("FAIL err_high_addr: got %h expected 0", aa); end
        do_access(0, 1'b1, 1'b0, 32'd1024, 32'h0, st, wl, aa, ok, rd);
        tests_run++; if (rd !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL err_high_wrapped: got %h expected cafef00d", rd); end
    endtask

    task automatic test_reset_mid_write();
        oe_a[0] = 1'b0;
        @(posedge clk); #1;
        wr_en_a[0] = 1'b1; address_a[0] = 32'd1028; wdata_a[0] = 32'h0BAD_F00D;
        @(posedge clk);
        @(posedge clk); #1;
        tests_run++; if (we_n_a[0] !== 1'b0) begin tests_failed++; $display("FAIL mid_in_access: got we_n %b expected 0", we_n_a[0]); end
        rst = 1'b0; wr_en_a[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++; if (ready_a[0] !== 1'b1) begin tests_failed++; $display("FAIL mid_ready: got %b expected 1", ready_a[0]); end
        tests_run++; if (we_n_a[0] !== 1'b1) begin tests_failed++; $display("FAIL mid_we_n: got %b expected 1", we_n_a[0]); end
        tests_run++; if (dq_a[0] !== 32'h0) begin tests_failed++; $display("FAIL mid_dq_released: got %h expected 0 (pulled-down bus)", dq_a[0]); end
        tests_run++; if (sram_addr_a[0] !== 17'd0) begin tests_failed++; $display("FAIL mid_sram_addr: got %h expected 0", sram_addr_a[0]); end
        @(posedge clk); #1;
        rst = 1'b1; oe_a[0] = 1'b1;
    endtask

    task automatic test_latency_sweep();
        int st, wl; logic [16:0] aa; logic ok; logic [31:0] rd;
        for (int k = 1; k < NI; k++) begin
            int w;
            logic [31:0] a, d;
            w = wc(k);
            a = 32'd1024 + 32'(4 * (16 + k));
            d = 32'hA500_0000 | 32'(w);
            do_access(k, 1'b0, 1'b1, a, d, st, wl, aa, ok, rd);
            tests_run++; if (st !== w + 1) begin tests_failed++; $display("FAIL sweep_w%0d_wr_stall: got %0d expected %0d", w, st, w + 1); end
            tests_run++; if (wl !== w) begin tests_failed++; $display("FAIL sweep_w%0d_we_low: got %0d expected %0d", w, wl, w); end
            tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL sweep_w%0d_dq: got bus mismatch flag %b expected 1", w, ok); end
            do_access(k, 1'b1, 1'b0, a, 32'h0, st, wl, aa, ok, rd);
            tests_run++; if (st !== w + 1) begin tests_failed++; $display("FAIL sweep_w%0d_rd_stall: got %0d expected %0d", w, st, w + 1); end
            tests_run++; if (rd !== d) begin tests_failed++; $display("FAIL sweep_w%0d_rd_data: got %h expected %h", w, rd, d); end
        end
    endtask

    task automatic test_held_request();
        logic [9:0]  pat;
        logic [31:0] rd3;
        logic        r10, r11;
        pat = '0; rd3 = '0;
        @(posedge clk); #1;
        rd_en_a[0] = 1'b1; address_a[0] = 32'd1032;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[i] = ready_a[0];
            if (i == 3) rd3 = rdata_a[0];
        end
        @(posedge clk); #1;
        rd_en_a[0] = 1'b0;
        @(negedge clk); r10 = ready_a[0];
        @(negedge clk); r11 = ready_a[0];
        tests_run++; if (pat !== 10'h088) begin tests_failed++; $display("FAIL held_ready_pattern: got %b expected %b", pat, 10'h088); end
        tests_run++; if (rd3 !== 32'h5555_AAAA) begin tests_failed++; $display("FAIL held_rdata: got %h expected 5555aaaa", rd3); end
        tests_run++; if ({r10, r11} !== 2'b01) begin tests_failed++; $display("FAIL held_tail: got %b expected 01", {r10, r11}); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            rd_en_a[k] = 1'b0; wr_en_a[k] = 1'b0; oe_a[k] = 1'b1;
            address_a[k] = '0; wdata_a[k] = '0;
        end
        test_reset();
        test_write_read();
        test_collision();
        test_range_err();
        test_reset_mid_write();
        test_latency_sweep();
        test_held_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100us expected $finish");
        $fatal(1, "watchdog expired");
    end
endmodule
